// File: rtl/disparity_search_ctrl.sv
// Steps one SAD engine through candidate disparities 0..n-1 for a single centre
// pixel and holds the lowest-SAD disparity on a valid/ready result port.
module disparity_search_ctrl #(
    parameter int MAX_DISP = 64,
    parameter int DISP_W   = 6,
    parameter int SAD_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [DISP_W:0]   cfg_num_disp,
    output logic              cand_req,
    output logic [DISP_W-1:0] cand_disp,
    input  logic              cand_valid,
    input  logic [SAD_W-1:0]  cand_sad,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [DISP_W-1:0] best_disp,
    output logic [SAD_W-1:0]  best_sad,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [DISP_W:0] MAX_N = (DISP_W+1)'(MAX_DISP);
    localparam logic [DISP_W:0] ONE_N = {{DISP_W{1'b0}}, 1'b1};

    state_t          state;
    logic [DISP_W:0] n;
    // One bit wider than cand_disp so n == 2^DISP_W terminates without wrapping.
    logic [DISP_W:0] d;
    logic [DISP_W:0] n_clamped;

    assign cand_disp = d[DISP_W-1:0];

    always_comb begin
        n_clamped = cfg_num_disp;
        if (cfg_num_disp == '0)
            n_clamped = ONE_N;
        else if (cfg_num_disp > MAX_N)
            n_clamped = MAX_N;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            n            <= ONE_N;
            d            <= '0;
            best_disp    <= '0;
            best_sad     <= '1;
            start_ready  <= 1'b1;
            cand_req     <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_valid) begin
                        state       <= RUN;
                        n           <= n_clamped;
                        d           <= '0;
                        best_disp   <= '0;
                        best_sad    <= '1;
                        start_ready <= 1'b0;
                        cand_req    <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    if (cand_valid) begin
                        // Strict less-than: ties keep the earlier (lower) disparity.
                        if (cand_sad < best_sad) begin
                            best_sad  <= cand_sad;
                            best_disp <= d[DISP_W-1:0];
                        end
                        if (d == n - ONE_N) begin
                            state        <= DONE;
                            cand_req     <= 1'b0;
                            result_valid <= 1'b1;
                        end else begin
                            d <= d + ONE_N;
                        end
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                        start_ready  <= 1'b1;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    start_ready  <= 1'b1;
                    cand_req     <= 1'b0;
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/disparity_search_ctrl.md
Name: disparity_search_ctrl

Overview:
- Sequences one SAD window-comparison engine across a range of candidate disparities for one centre pixel and reports the winning disparity.
- Issues one candidate request per disparity (d = 0 .. N-1) to the upstream window buffer / SAD pipeline and consumes the returned SAD values.
- Tracks the running minimum and presents best disparity and best SAD on a valid/ready result port.
- Sits between the line/window buffers plus SAD datapath and the disparity-map writer.

Parameters:
MAX_DISP, 64, largest supported number of candidate disparities
DISP_W, 6, width of disparity index; must satisfy 2^DISP_W >= MAX_DISP
SAD_W, 12, width of SAD values; default covers 9 x 255 = 2295

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
start_valid  input  1  request a new search
start_ready  output  1  high only in IDLE
cfg_num_disp  input  DISP_W+1  number of candidates; sampled when start is accepted
cand_req  output  1  candidate request pending
cand_disp  output  DISP_W  disparity of the pending candidate
cand_valid  input  1  SAD for cand_disp is present on cand_sad
cand_sad  input  SAD_W  SAD result for the current candidate
result_valid  output  1  search complete, result held
result_ready  input  1  downstream accepts result
best_disp  output  DISP_W  winning disparity
best_sad  output  SAD_W  SAD of the winning disparity
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert; synchronous release assumed upstream): state=IDLE; cand_req=0; cand_disp=0; result_valid=0; best_disp=0; best_sad=all-ones; internal count=0. Reset mid-search abandons the search, emits no result and returns to IDLE.
- States are IDLE, RUN and DONE.
- IDLE:
  - start_ready=1.
  - start_valid=1 accepts the search: latch n = clamp(cfg_num_disp); best_sad=all-ones; best_disp=0; cand_disp=0; go to RUN.
  - clamp: 0 -> 1; values > MAX_DISP -> MAX_DISP.
- RUN:
  - cand_req=1, cand_disp=d.
  - A candidate is accepted on a cycle where cand_req and cand_valid are both high. cand_sad is sampled on that same edge.
  - Update rule: if cand_sad < best_sad (strict, unsigned), then best_sad=cand_sad and best_disp=d. Ties keep the lower disparity.
  - After the accept, if d == n-1 go to DONE; otherwise d = d+1.
  - cand_valid while cand_req=0 is ignored.
  - cand_disp and cand_req are held stable until the accept.
- DONE:
  - result_valid=1; best_disp/best_sad are stable; cand_req=0.
  - result_ready=1 returns to IDLE; result_valid drops on the next cycle.
  - start_valid is ignored (start_ready=0) until IDLE is re-entered. A new start is accepted no earlier than the cycle after the result handshake.
- Latency: start accepted at edge 0; cand_req high from cycle 1. With cand_valid tied high, n candidates take n cycles, and result_valid rises in cycle n+1.
- Each cand_valid stall adds exactly one cycle.
- Width rules:
  - Comparison is unsigned at SAD_W bits.
  - The disparity counter is DISP_W+1 bits internally, so n = MAX_DISP = 2^DISP_W terminates correctly without wrap.
  - An all-ones cand_sad never beats the initial best, so best_disp stays 0.
- start_valid and rst high together: reset wins.

Test Plan:
1. Reset, then start with cfg_num_disp=4 and cand_valid tied high; SADs 50,20,30,20 -> result_valid in cycle 5, best_disp=1, best_sad=20 (tie at d=3 rejected).
2. cfg_num_disp=0 -> exactly one request (cand_disp=0); SAD 7 -> best_disp=0, best_sad=7.
3. cfg_num_disp=100 with MAX_DISP=64, descending SADs 1000-d -> 64 requests, last cand_disp=63, best_disp=63, best_sad=937.
4. cand_valid low for 3 cycles at d=2 -> cand_disp stays 2 and cand_req stays high for 3 cycles; total search n+3 cycles; result is the same as without the stall.
5. Hold result_ready=0 for 10 cycles in DONE -> result_valid/best_* stable, start_ready=0, start_valid pulses ignored. Then result_ready=1 -> IDLE next cycle, start accepted the cycle after.
6. Assert rst at d=5 of an 8-candidate search -> outputs return immediately to reset values, no result_valid. A new start after release gives a correct independent result.
